// File: rtl/spi_flash_rd_arb.sv
// spi_flash_rd_arb: two-port read arbiter for a single-bit SPI flash (cmd 0x03, mode 0).
// Port A (data) and port B (instruction fetch) share the flash with round-robin on ties.
// Each request shifts out 0x03 plus a 24-bit address and shifts in one byte.
// Optional feature macro: SPI_ARB_CONT_EN. When it is defined, chip select stays low after a
// read so that a sequential read from the same port can continue straight into the data phase.
module spi_flash_rd_arb #(
    parameter int CS_HOLD      = 2,
    parameter int CONT_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_req,
    input  logic [23:0] a_addr,
    output logic [7:0]  a_rdata,
    output logic        a_ready,
    input  logic        b_req,
    input  logic [23:0] b_addr,
    output logic [7:0]  b_rdata,
    output logic        b_ready,
    output logic        busy,
    output logic        spi_csb,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    // The counter has to cover the 64 half-bits of the command/address phase and both timers.
    localparam int CNT_MAX0 = (CONT_TIMEOUT > 64) ? CONT_TIMEOUT : 64;
    localparam int CNT_MAX  = (CS_HOLD > CNT_MAX0) ? CS_HOLD : CNT_MAX0;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_CA = 3'd2,
        ST_SHIFT_D  = 3'd3,
        ST_DONE     = 3'd4,
        ST_CS_HIGH  = 3'd5,
        ST_HOLD     = 3'd6
    } state_t;

    state_t             state_r, state_s;
    logic [CNT_W-1:0]   cnt_r, cnt_s;
    logic [31:0]        sh_r, sh_s;
    logic [7:0]         dsh_r, dsh_s;
    logic               port_r, port_s;        // 1 = port B owns the current transfer
    logic               rr_last_r, rr_last_s;  // 1 = port B was granted last
    logic [23:0]        addr_r, addr_s;
    logic               csb_r, csb_s;
    logic               sclk_r, sclk_s;
    logic               mosi_r, mosi_s;
    logic [7:0]         a_rdata_r, a_rdata_s;
    logic [7:0]         b_rdata_r, b_rdata_s;
    logic               a_ready_r, a_ready_s;
    logic               b_ready_r, b_ready_s;
    logic               busy_r, busy_s;

    logic               any_req_s;
    logic               win_b_s;
    logic [23:0]        sel_addr_s;
    logic [7:0]         din_s;

    // Round-robin: on a tie the port that was not granted last wins.
    assign any_req_s  = a_req | b_req;
    assign win_b_s    = b_req & (~a_req | ~rr_last_r);
    assign sel_addr_s = win_b_s ? b_addr : a_addr;
    assign din_s      = {dsh_r[6:0], spi_miso};

    // Next-state and next-output logic; all pins are registered from these values.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        sh_s      = sh_r;
        dsh_s     = dsh_r;
        port_s    = port_r;
        rr_last_s = rr_last_r;
        addr_s    = addr_r;
        csb_s     = csb_r;
        sclk_s    = 1'b0;
        mosi_s    = mosi_r;
        a_rdata_s = a_rdata_r;
        b_rdata_s = b_rdata_r;
        a_ready_s = 1'b0;
        b_ready_s = 1'b0;

        case (state_r)
            ST_IDLE: begin
                csb_s  = 1'b1;
                mosi_s = 1'b0;
                if (any_req_s) begin
                    state_s   = ST_SETUP;
                    port_s    = win_b_s;
                    rr_last_s = win_b_s;
                    addr_s    = sel_addr_s;
                    sh_s      = {8'h03, sel_addr_s};
                    csb_s     = 1'b0;
                end else begin
                    state_s   = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_s = ST_SHIFT_CA;
                cnt_s   = {CNT_W{1'b0}};
                mosi_s  = sh_r[31];
            end
            ST_SHIFT_CA: begin
                if (!cnt_r[0]) begin
                    sclk_s = 1'b1;
                    cnt_s  = cnt_r + CNT_W'(1);
                end else begin
                    sh_s = {sh_r[30:0], 1'b0};
                    if (cnt_r == CNT_W'(63)) begin
                        state_s = ST_SHIFT_D;
                        cnt_s   = {CNT_W{1'b0}};
                        mosi_s  = 1'b0;
                    end else begin
                        cnt_s   = cnt_r + CNT_W'(1);
                        mosi_s  = sh_r[30];
                    end
                end
            end
            ST_SHIFT_D: begin
                mosi_s = 1'b0;
                if (!cnt_r[0]) begin
                    sclk_s = 1'b1;
                    cnt_s  = cnt_r + CNT_W'(1);
                end else begin
                    // This edge drops sclk, so the flash bit is captured here.
                    dsh_s = din_s;
                    if (cnt_r == CNT_W'(15)) begin
                        state_s = ST_DONE;
                        cnt_s   = {CNT_W{1'b0}};
                        if (port_r) begin
                            b_rdata_s = din_s;
                            b_ready_s = 1'b1;
                        end else begin
                            a_rdata_s = din_s;
                            a_ready_s = 1'b1;
                        end
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end
            end
            ST_DONE: begin
                cnt_s = {CNT_W{1'b0}};
`ifdef SPI_ARB_CONT_EN
                state_s = ST_HOLD;
                csb_s   = 1'b0;
`else
                state_s = ST_CS_HIGH;
                csb_s   = 1'b1;
`endif
            end
            ST_CS_HIGH: begin
                csb_s = 1'b1;
                if (cnt_r == CNT_W'(CS_HOLD - 1)) begin
                    state_s = ST_IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_HOLD: begin
`ifdef SPI_ARB_CONT_EN
                if (any_req_s) begin
                    // A sequential hit only counts if the previous owner also wins arbitration.
                    if ((win_b_s == port_r) && (sel_addr_s == addr_r + 24'd1)) begin
                        state_s   = ST_SHIFT_D;
                        cnt_s     = {CNT_W{1'b0}};
                        addr_s    = addr_r + 24'd1;
                        rr_last_s = win_b_s;
                    end else begin
                        state_s = ST_CS_HIGH;
                        cnt_s   = {CNT_W{1'b0}};
                        csb_s   = 1'b1;
                    end
                end else if (cnt_r == CNT_W'(CONT_TIMEOUT - 1)) begin
                    state_s = ST_CS_HIGH;
                    cnt_s   = {CNT_W{1'b0}};
                    csb_s   = 1'b1;
                end else begin
                    cnt_s   = cnt_r + CNT_W'(1);
                end
`else
                state_s = ST_CS_HIGH;
                cnt_s   = {CNT_W{1'b0}};
                csb_s   = 1'b1;
`endif
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = {CNT_W{1'b0}};
                csb_s   = 1'b1;
                mosi_s  = 1'b0;
            end
        endcase

        busy_s = (state_s != ST_IDLE);
    end

    // State, datapath and registered pin update; reset is asynchronous and immediate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNT_W{1'b0}};
            sh_r      <= 32'h0000_0000;
            dsh_r     <= 8'h00;
            port_r    <= 1'b0;
            rr_last_r <= 1'b1;
            addr_r    <= 24'h00_0000;
            csb_r     <= 1'b1;
            sclk_r    <= 1'b0;
            mosi_r    <= 1'b0;
            a_rdata_r <= 8'h00;
            b_rdata_r <= 8'h00;
            a_ready_r <= 1'b0;
            b_ready_r <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            cnt_r     <= cnt_s;
            sh_r      <= sh_s;
            dsh_r     <= dsh_s;
            port_r    <= port_s;
            rr_last_r <= rr_last_s;
            addr_r    <= addr_s;
            csb_r     <= csb_s;
            sclk_r    <= sclk_s;
            mosi_r    <= mosi_s;
            a_rdata_r <= a_rdata_s;
            b_rdata_r <= b_rdata_s;
            a_ready_r <= a_ready_s;
            b_ready_r <= b_ready_s;
            busy_r    <= busy_s;
        end
    end

    assign a_rdata  = a_rdata_r;
    assign a_ready  = a_ready_r;
    assign b_rdata  = b_rdata_r;
    assign b_ready  = b_ready_r;
    assign busy     = busy_r;
    assign spi_csb  = csb_r;
    assign spi_sclk = sclk_r;
    assign spi_mosi = mosi_r;

endmodule

// File: tb/tb_spi_flash_rd_arb.sv
// Testbench for spi_flash_rd_arb: behavioural serial flash, round-robin/latency reference model,
// randomized request patterns. Continuation tests are compiled when SPI_ARB_CONT_EN is defined.
module tb_spi_flash_rd_arb;

    localparam int CS_HOLD      = 2;
    localparam int CONT_TIMEOUT = 16;
`ifdef SPI_ARB_CONT_EN
    localparam int CONT = 1;
`else
    localparam int CONT = 0;
`endif
    localparam int LAT_FULL = 82;
    localparam int LAT_CONT = 17;
    localparam int GAP      = LAT_FULL + CS_HOLD + 1 + CONT;
    localparam int IDLE_GAP = CS_HOLD + 1 + CONT * CONT_TIMEOUT;

    logic        clk, rst_n;
    logic        a_req, b_req;
    logic [23:0] a_addr, b_addr;
    logic [7:0]  a_rdata, b_rdata;
    logic        a_ready, b_ready, busy;
    logic        spi_csb, spi_sclk, spi_mosi;
    logic        fl_miso;

    int errors = 0;
    int checks = 0;

    spi_flash_rd_arb #(.CS_HOLD(CS_HOLD), .CONT_TIMEOUT(CONT_TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_addr(a_addr), .a_rdata(a_rdata), .a_ready(a_ready),
        .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata), .b_ready(b_ready),
        .busy(busy), .spi_csb(spi_csb), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi),
        .spi_miso(fl_miso)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash contents: a byte table folded with the upper address bytes.
    logic [7:0] mem [256];
    function automatic logic [7:0] flash_byte(input logic [23:0] ad);
        return mem[ad[7:0]] ^ ad[15:8] ^ ad[23:16];
    endfunction

    // Flash model: command/address in on sclk rise, data out on sclk fall, streams on.
    logic [31:0] fl_sh;
    int          fl_cnt;
    logic [7:0]  cap_cmd;
    logic [23:0] cap_addr;
    int          fl_d;
    logic [7:0]  fl_byte;

    // Command/address capture; chip select high restarts the sequence.
    always @(posedge spi_sclk or posedge spi_csb) begin
        if (spi_csb) begin
            fl_cnt = 0;
        end else begin
            if (fl_cnt < 32) fl_sh = {fl_sh[30:0], spi_mosi};
            fl_cnt = fl_cnt + 1;
            if (fl_cnt == 32) begin
                cap_cmd  = fl_sh[31:24];
                cap_addr = fl_sh[23:0];
            end
        end
    end

    // Data output, MSB first, address auto-incrementing each byte.
    always @(negedge spi_sclk) begin
        if (!spi_csb && fl_cnt >= 32) begin
            fl_d    = fl_cnt - 32;
            fl_byte = flash_byte(cap_addr + 24'(fl_d / 8));
            fl_miso <= #1 fl_byte[3'(7 - (fl_d % 8))];
        end
    end

    // Pin-protocol monitor.
    int   viol = 0;
    int   csb_rises = 0;
    logic prev_csb = 1'b1, prev_sclk = 1'b0, prev_ar = 1'b0, prev_br = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            if (spi_csb && spi_sclk) viol++;
            if ((spi_csb != prev_csb) && (spi_sclk || prev_sclk)) viol++;
            if (a_ready && b_ready) viol++;
            if ((a_ready && prev_ar) || (b_ready && prev_br)) viol++;
            if (spi_csb && !prev_csb) csb_rises++;
        end
        prev_csb  = spi_csb;
        prev_sclk = spi_sclk;
        prev_ar   = a_ready;
        prev_br   = b_ready;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference state: last granted port (1 = B) and each port's last returned byte.
    logic       last_port;
    logic [7:0] model_rd [2];

    task automatic wait_ready(output logic port, output int cyc);
        cyc = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            cyc++;
            if (a_ready || b_ready) break;
        end
        check_val("ready_seen", {31'd0, a_ready | b_ready}, 32'd1);
        port = b_ready;
    endtask

    task automatic run_pair(input logic ra, input logic rb, input logic [23:0] aa, input logic [23:0] ab);
        logic first, expp, port;
        int   n, cyc;
        logic [7:0] d;
        @(negedge clk);
        a_req = ra; a_addr = aa; b_req = rb; b_addr = ab;
        first = (ra && rb) ? ~last_port : rb;
        n = (ra && rb) ? 2 : 1;
        for (int k = 0; k < n; k++) begin
            expp = (k == 0) ? first : ~first;
            wait_ready(port, cyc);
            check_val("grant_port", {31'd0, port}, {31'd0, expp});
            check_val((k == 0) ? "latency" : "gap", cyc, (k == 0) ? LAT_FULL : GAP);
            d = flash_byte(expp ? ab : aa);
            check_val("rdata", {24'd0, expp ? b_rdata : a_rdata}, {24'd0, d});
            check_val("other_rdata", {24'd0, expp ? a_rdata : b_rdata}, {24'd0, model_rd[~expp]});
            check_val("mosi_cmd", {24'd0, cap_cmd}, 32'h03);
            check_val("mosi_addr", {8'd0, cap_addr}, {8'd0, expp ? ab : aa});
            model_rd[expp] = d;
            last_port = expp;
            if (expp) b_req = 1'b0; else a_req = 1'b0;
        end
        repeat (IDLE_GAP) @(negedge clk);
    endtask

    initial begin
        logic p;
        int   cyc, r0, pat;
        for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
        mem[4] = 8'hA5;
        fl_miso = 1'b0;
        rst_n = 1'b0; a_req = 1'b0; b_req = 1'b0; a_addr = 24'd0; b_addr = 24'd0;
        last_port = 1'b1; model_rd[0] = 8'h00; model_rd[1] = 8'h00;

        repeat (3) @(negedge clk);
        check_val("rst_csb",  {31'd0, spi_csb},  32'd1);
        check_val("rst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_val("rst_mosi", {31'd0, spi_mosi}, 32'd0);
        check_val("rst_busy", {31'd0, busy},     32'd0);
        check_val("rst_ardy", {31'd0, a_ready},  32'd0);
        check_val("rst_brdy", {31'd0, b_ready},  32'd0);
        check_val("rst_ard",  {24'd0, a_rdata},  32'd0);
        check_val("rst_brd",  {24'd0, b_rdata},  32'd0);
        rst_n = 1'b1;

        // Directed: tie from reset (A first), tie again (A), A alone at 0x4, tie (B).
        run_pair(1'b1, 1'b1, 24'h000100, 24'h000200);
        run_pair(1'b1, 1'b1, 24'h123456, 24'hFEDCBA);
        run_pair(1'b1, 1'b0, 24'h000004, 24'h000000);
        check_val("flash4", {24'd0, a_rdata}, 32'hA5);
        run_pair(1'b1, 1'b1, 24'hFFFFFF, 24'h000000);

        // Randomized request patterns.
        for (int it = 0; it < 16; it++) begin
            pat = $urandom_range(1, 3);
            run_pair(pat[0], pat[1], 24'($urandom), 24'($urandom));
        end

`ifdef SPI_ARB_CONT_EN
        // Sequential continuation on port B.
        @(negedge clk);
        b_req = 1'b1; b_addr = 24'h000010;
        wait_ready(p, cyc);
        check_val("c1_port", {31'd0, p}, 32'd1);
        check_val("c1_lat", cyc, LAT_FULL);
        check_val("c1_data", {24'd0, b_rdata}, {24'd0, flash_byte(24'h000010)});
        b_req = 1'b0; last_port = 1'b1; model_rd[1] = flash_byte(24'h000010);
        r0 = csb_rises;
        @(negedge clk);
        check_val("hold_csb", {31'd0, spi_csb}, 32'd0);
        b_addr = 24'h000011; b_req = 1'b1;
        wait_ready(p, cyc);
        check_val("c2_port", {31'd0, p}, 32'd1);
        check_val("c2_lat", cyc, LAT_CONT);
        check_val("c2_data", {24'd0, b_rdata}, {24'd0, flash_byte(24'h000011)});
        check_val("c2_csb_rises", csb_rises - r0, 32'd0);
        b_req = 1'b0; model_rd[1] = flash_byte(24'h000011);
        repeat (CONT_TIMEOUT) @(negedge clk);
        check_val("hold_last_csb", {31'd0, spi_csb}, 32'd0);
        @(negedge clk);
        check_val("timeout_csb", {31'd0, spi_csb}, 32'd1);
        repeat (CS_HOLD) @(negedge clk);
        b_addr = 24'h000012; b_req = 1'b1;
        wait_ready(p, cyc);
        check_val("c3_lat", cyc, LAT_FULL);
        check_val("c3_data", {24'd0, b_rdata}, {24'd0, flash_byte(24'h000012)});
        check_val("c3_addr", {8'd0, cap_addr}, 32'h000012);
        b_req = 1'b0; model_rd[1] = flash_byte(24'h000012);
        repeat (IDLE_GAP) @(negedge clk);
`endif

        // Reset in the middle of the command/address phase.
        @(negedge clk);
        a_req = 1'b1; a_addr = 24'($urandom);
        repeat (20) @(negedge clk);
        check_val("mid_busy", {31'd0, busy}, 32'd1);
        check_val("mid_csb", {31'd0, spi_csb}, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_csb",  {31'd0, spi_csb},  32'd1);
        check_val("arst_sclk", {31'd0, spi_sclk}, 32'd0);
        check_val("arst_mosi", {31'd0, spi_mosi}, 32'd0);
        check_val("arst_busy", {31'd0, busy},     32'd0);
        check_val("arst_ard",  {24'd0, a_rdata},  32'd0);
        a_req = 1'b0;
        last_port = 1'b1; model_rd[0] = 8'h00; model_rd[1] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        run_pair(1'b1, 1'b1, 24'h000004, 24'h0ABCDE);

        check_val("protocol_viol", viol, 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
